// File: rtl/if_fetch.sv
// if_fetch : instruction-fetch stage feeding the IF/ID pipeline register.
//
// Owns the PC and runs a single-outstanding req/ack fetch to instruction
// memory. Returned instructions land in a 2-entry FIFO whose head drives
// IF_valid / IF_pc / IF_inst. A redirect from EX flushes the FIFO; if a
// request is still in flight it is drained (DROP) before the new target
// is fetched.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   IF_ID_stall     IF/ID hold, head entry not consumed
//   redirect_valid  one-cycle redirect pulse from EX
//   redirect_pc     redirect target (bits [1:0] ignored)
//   imem_req/addr   fetch request and address (address stable until ack)
//   imem_ack/rdata  response strobe and instruction word
//   IF_valid/pc/inst  FIFO head towards IF/ID (zero when empty)
module if_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [63:0] PC_STEP  = 64'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_ID_stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        IF_valid,
  output logic [63:0] IF_pc,
  output logic [31:0] IF_inst
);

  typedef enum logic {FETCH, DROP} fsm_e;

  fsm_e        fsm_q, fsm_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] tgt_q, tgt_d;
  logic        ost_q, ost_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [63:0] fpc_q [2];
  logic [63:0] fpc_d [2];
  logic [31:0] finst_q [2];
  logic [31:0] finst_d [2];

  logic        ack;
  logic        push;
  logic        pop;
  logic [1:0]  cnt_pp;
  logic [63:0] redir_al;

  always_comb begin
    // Keep asking while a request is in flight (address must stay stable),
    // otherwise only while fetching and the FIFO has room.
    imem_req  = !rst && (ost_q || (fsm_q == FETCH && cnt_q != 2'd2));
    imem_addr = pc_q;
    redir_al  = {redirect_pc[63:2], 2'b00};
    ack       = imem_req && imem_ack;
    pop       = (cnt_q != 2'd0) && !IF_ID_stall && !redirect_valid;
    push      = ack && (fsm_q == FETCH) && !redirect_valid;
    cnt_pp    = cnt_q - {1'b0, pop};

    fsm_d   = fsm_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    ost_d   = imem_req && !imem_ack;
    cnt_d   = cnt_pp + {1'b0, push};
    fpc_d   = fpc_q;
    finst_d = finst_q;

    // FIFO is kept head-aligned in entry 0 so the outputs are plain flops.
    if (pop) begin
      fpc_d[0]   = fpc_q[1];
      finst_d[0] = finst_q[1];
      fpc_d[1]   = '0;
      finst_d[1] = '0;
    end
    if (push) begin
      if (cnt_pp == 2'd0) begin
        fpc_d[0]   = pc_q;
        finst_d[0] = imem_rdata;
      end else begin
        fpc_d[1]   = pc_q;
        finst_d[1] = imem_rdata;
      end
    end

    if (redirect_valid) begin
      cnt_d = 2'd0;
      if (imem_req && !imem_ack) begin
        // Memory still owns the current address: park the target and drain.
        tgt_d = redir_al;
        fsm_d = DROP;
      end else begin
        pc_d  = redir_al;
        fsm_d = FETCH;
      end
    end else if (fsm_q == DROP && ack) begin
      pc_d  = tgt_q;
      fsm_d = FETCH;
    end else if (push) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= FETCH;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      ost_q   <= 1'b0;
      cnt_q   <= 2'd0;
      fpc_q   <= '{default: '0};
      finst_q <= '{default: '0};
    end else begin
      fsm_q   <= fsm_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      ost_q   <= ost_d;
      cnt_q   <= cnt_d;
      fpc_q   <= fpc_d;
      finst_q <= finst_d;
    end
  end

  always_comb begin
    IF_valid = !rst && (cnt_q != 2'd0);
    IF_pc    = IF_valid ? fpc_q[0] : '0;
    IF_inst  = IF_valid ? finst_q[0] : '0;
  end

endmodule
